// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard front end: pin conditioning, 11-bit frame capture with parity/stop checks,
// and make/break/extended decoding with Shift and Caps Lock tracking.
module ps2_key_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       letter_case,
  output logic       frame_error
);

  localparam int unsigned FiltW       = $clog2(FILTER_LEN + 1);
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CodeBreak  = 8'hF0;
  localparam logic [7:0] CodeExt    = 8'hE0;
  localparam logic [7:0] CodeLShift = 8'h12;
  localparam logic [7:0] CodeRShift = 8'h59;
  localparam logic [7:0] CodeCaps   = 8'h58;

  typedef enum logic [1:0] {StIdle, StRx, StCheck} state_e;

  // Synchronisers reset to 1 so an idle bus produces no edge out of reset.
  logic c_meta, c_sync, d_meta, d_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
    end
  end

  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             fall_q;

  // Counts consecutive samples that disagree with the filtered level; any agreeing sample restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (c_sync != filt_q) begin
        if (filt_cnt_q == FiltLast) begin
          filt_q     <= c_sync;
          filt_cnt_q <= '0;
          fall_q     <= filt_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [9:0]  shreg_q;
  logic [15:0] timer_q;
  logic        pend_q, pend_d_q;
  logic        brk_q, ext_q, lshift_q, rshift_q, caps_q;
  logic [7:0]  scan_code_q;
  logic        ready_q, ferr_q, case_q;

  logic [7:0] rx_byte;
  logic       frame_ok;
  logic       start_seen;

  assign rx_byte    = shreg_q[7:0];
  assign frame_ok   = (^shreg_q[8:0]) & shreg_q[9];
  // An edge swallowed by the CHECK cycle is replayed here as a start-bit candidate.
  assign start_seen = (fall_q & ~d_sync) | (pend_q & ~pend_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      pend_d_q    <= 1'b1;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      scan_code_q <= '0;
      ready_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      pend_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_seen) begin
            bit_cnt_q <= '0;
            timer_q   <= '0;
            state_q   <= StRx;
          end
        end
        StRx: begin
          if (fall_q) begin
            shreg_q   <= {d_sync, shreg_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            timer_q   <= '0;
            if (bit_cnt_q == 4'd9) state_q <= StCheck;
          end else if (timer_q == TimeoutLast) begin
            state_q <= StIdle;
            ferr_q  <= 1'b1;
          end else if (timer_q != 16'hFFFF) begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StCheck: begin
          state_q  <= StIdle;
          pend_q   <= fall_q;
          pend_d_q <= d_sync;
          if (!frame_ok) begin
            ferr_q <= 1'b1;
          end else if (rx_byte == CodeBreak) begin
            brk_q <= 1'b1;
          end else if (rx_byte == CodeExt) begin
            ext_q <= 1'b1;
          end else if (brk_q) begin
            if (rx_byte == CodeLShift) lshift_q <= 1'b0;
            if (rx_byte == CodeRShift) rshift_q <= 1'b0;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
          end else if (ext_q) begin
            ext_q <= 1'b0;
          end else if (rx_byte == CodeLShift) begin
            lshift_q <= 1'b1;
          end else if (rx_byte == CodeRShift) begin
            rshift_q <= 1'b1;
          end else if (rx_byte == CodeCaps) begin
            caps_q <= ~caps_q;
          end else begin
            scan_code_q <= rx_byte;
            ready_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      case_q <= 1'b0;
    end else begin
      case_q <= (lshift_q | rshift_q) ^ caps_q;
    end
  end

  assign scan_code       = scan_code_q;
  assign scan_code_ready = ready_q;
  assign frame_error     = ferr_q;
  assign letter_case     = case_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed plus randomized bench for ps2_key_receiver against a byte-level keyboard model.
module tb_ps2_key_receiver;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 600;
  localparam int unsigned HP = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       letter_case;
  logic       frame_error;

  ps2_key_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2c           (ps2c),
    .ps2d           (ps2d),
    .scan_code      (scan_code),
    .scan_code_ready(scan_code_ready),
    .letter_case    (letter_case),
    .frame_error    (frame_error)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  got_codes[$];
  logic        got_case[$];
  int          got_err = 0;
  int          wide = 0;
  int unsigned last_rdy_cyc = 0;
  logic        prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (scan_code_ready) begin
        got_codes.push_back(scan_code);
        got_case.push_back(letter_case);
        last_rdy_cyc = cyc;
        if (prev_rdy) wide++;
      end
      if (frame_error) got_err++;
      prev_rdy = scan_code_ready;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  // Keyboard model
  bit         m_brk, m_ext, m_ls, m_rs, m_caps;
  logic [7:0] exp_codes[$];
  logic       exp_case[$];
  int         exp_err = 0;

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      if (b == 8'h12) m_ls = 0;
      if (b == 8'h59) m_rs = 0;
      m_brk = 0;
      m_ext = 0;
    end else if (m_ext) m_ext = 0;
    else if (b == 8'h12) m_ls = 1;
    else if (b == 8'h59) m_rs = 1;
    else if (b == 8'h58) m_caps = ~m_caps;
    else begin
      exp_codes.push_back(b);
      exp_case.push_back((m_ls | m_rs) ^ m_caps);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int unsigned fall_cyc = 0;

  task automatic drive_bit(input logic v, input bit glitch);
    @(posedge clk); #1;
    ps2d = v;
    if (glitch) begin
      repeat (HP / 2) @(posedge clk);
      #3 ps2c = 1'b0;
      #5 ps2c = 1'b1;
      repeat (HP / 2) @(posedge clk);
    end else begin
      repeat (HP) @(posedge clk);
    end
    #1;
    ps2c = 1'b0;
    fall_cyc = cyc;
    repeat (HP) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], glitch);
    @(posedge clk); #1 ps2d = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, got_codes.size(), exp_codes.size());
    if (got_codes.size() == exp_codes.size() && exp_codes.size() > 0) begin
      check({tag, ".code"}, got_codes[$], exp_codes[$]);
      check({tag, ".pcase"}, got_case[$], exp_case[$]);
    end
    check({tag, ".ferr"}, got_err, exp_err);
    check({tag, ".case"}, letter_case, (m_ls | m_rs) ^ m_caps);
    check({tag, ".width"}, wide, 0);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad, input bit glitch, input string tag);
    send_frame(b, bad, 11, glitch);
    repeat (30) @(posedge clk);
    if (bad) exp_err++;
    else model_byte(b);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] pool [6];
    logic [7:0] rb;
    bit         rbad;
    pool[0] = 8'h12; pool[1] = 8'h59; pool[2] = 8'h58;
    pool[3] = 8'hF0; pool[4] = 8'hE0; pool[5] = 8'h1C;
    model_reset();

    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.code", scan_code, 8'h00);
    check("rst.rdy", scan_code_ready, 1'b0);
    check("rst.ferr", frame_error, 1'b0);
    check("rst.case", letter_case, 1'b0);
    repeat (20) @(posedge clk);

    frame(8'h1C, 0, 0, "a");
    check("a.latency", last_rdy_cyc - fall_cyc, FL + 4);

    frame(8'h12, 0, 0, "sh.12");
    frame(8'h1C, 0, 0, "sh.1C");
    check("sh.upper", got_case[$], 1'b1);
    frame(8'hF0, 0, 0, "sh.f0a");
    frame(8'h1C, 0, 0, "sh.r1C");
    frame(8'hF0, 0, 0, "sh.f0b");
    frame(8'h12, 0, 0, "sh.r12");
    check("sh.after", letter_case, 1'b0);

    frame(8'h58, 0, 0, "cl.58");
    frame(8'hF0, 0, 0, "cl.f0");
    frame(8'h58, 0, 0, "cl.r58");
    frame(8'h1C, 0, 0, "cl.1C");
    check("cl.upper", got_case[$], 1'b1);
    frame(8'h58, 0, 0, "cl.58b");
    check("cl.off", letter_case, 1'b0);

    frame(8'h1C, 1, 0, "par.bad");
    frame(8'h1B, 0, 0, "par.next");

    send_frame(8'hA5, 0, 5, 0);
    repeat (2 * TO) @(posedge clk);
    exp_err++;
    check_state("to");
    frame(8'h2D, 0, 0, "to.next");

    frame(8'hE0, 0, 1, "ex.e0a");
    frame(8'h75, 0, 1, "ex.75");
    frame(8'hE0, 0, 1, "ex.e0b");
    frame(8'hF0, 0, 1, "ex.f0");
    frame(8'h75, 0, 1, "ex.r75");
    frame(8'h2D, 0, 1, "gl.2D");

    frame(8'h12, 0, 0, "mr.12");
    send_frame(8'h1C, 0, 6, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (30) @(posedge clk);
    check_state("mr.after");
    frame(8'h1C, 0, 0, "mr.1C");

    for (int i = 0; i < 25; i++) begin
      rb   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
      rbad = ($urandom_range(0, 7) == 0);
      frame(rb, rbad, 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
